// File: rtl/rob_commit.sv
// Reorder buffer for the Tomasulo core: allocates at the tail, marks entries complete from the CDB, retires in order.
// Optional macro ROB_COMMIT_BYPASS_EN lets a CDB result for the head entry retire in the same cycle it arrives.
module rob_commit #(
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 16,
  parameter int REG_W     = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [3:0]        alloc_func,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic              commit_we,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  input  logic              flush,
  output logic [TAG_W-1:0]  head_p,
  output logic [TAG_W-1:0]  tail_p,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(ROB_DEPTH);

  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return p + 1'b1;
  endfunction

  function automatic logic is_branch(input logic [3:0] func);
    return func[3:2] == 2'b01;
  endfunction

  // control state
  logic [ROB_DEPTH-1:0] ent_vld;
  logic [ROB_DEPTH-1:0] ent_rdy;
  logic [TAG_W-1:0]     head_q;
  logic [TAG_W-1:0]     tail_q;
  logic [TAG_W:0]       count_q;

  // payload storage, never reset: it is only observed behind a set valid bit
  logic [3:0]           ent_func [ROB_DEPTH];
  logic [REG_W-1:0]     ent_rd   [ROB_DEPTH];
  logic [DATA_W-1:0]    ent_data [ROB_DEPTH];

  logic              head_vld;
  logic              head_rdy;
  logic              head_commit;
  logic [DATA_W-1:0] head_data;
  logic              cdb_hit;
  logic              alloc_fire;
  logic              commit_fire;
  logic              unused_func;

  assign head_vld = ent_vld[head_q];
  assign head_rdy = ent_rdy[head_q];
  assign cdb_hit  = cdb_valid && ent_vld[cdb_tag];

`ifdef ROB_COMMIT_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit  = head_vld && !head_rdy && cdb_valid && (cdb_tag == head_q);
  assign head_commit = head_vld && (head_rdy || bypass_hit);
  assign head_data   = bypass_hit ? cdb_data : ent_data[head_q];
`else
  assign head_commit = head_vld && head_rdy;
  assign head_data   = ent_data[head_q];
`endif

  // Flush still shows the head combinationally but discards both handshakes.
  assign alloc_ready = (count_q != FULL_CNT);
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign commit_fire = head_commit && commit_ready && !flush;

  // The low opcode bits select the ALU operation and play no part in retirement.
  assign unused_func = ^ent_func[head_q][1:0];

  assign alloc_tag    = tail_q;
  assign head_p       = head_q;
  assign tail_p       = tail_q;
  assign count        = count_q;
  assign commit_valid = head_commit;
  assign commit_tag   = head_q;
  assign commit_we    = head_commit && !is_branch(ent_func[head_q]);
  assign commit_rd    = head_commit ? ent_rd[head_q] : '0;
  assign commit_data  = head_commit ? head_data : '0;

  // Entry state update: CDB, then commit, then allocate, so allocation wins on a shared index.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld <= '0;
      ent_rdy <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      ent_vld <= '0;
      ent_rdy <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (cdb_hit) begin
        ent_rdy[cdb_tag] <= 1'b1;
      end
      if (commit_fire) begin
        ent_vld[head_q] <= 1'b0;
        ent_rdy[head_q] <= 1'b0;
        head_q          <= ptr_inc(head_q);
      end
      if (alloc_fire) begin
        ent_vld[tail_q] <= 1'b1;
        ent_rdy[tail_q] <= 1'b0;
        tail_q          <= ptr_inc(tail_q);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (alloc_fire) begin
      ent_func[tail_q] <= alloc_func;
      ent_rd[tail_q]   <= alloc_rd;
    end
    if (cdb_hit && !flush) begin
      ent_data[cdb_tag] <= cdb_data;
    end
  end

endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder-buffer storage and in-order retirement unit for the Tomasulo core. Issue allocates entries at the tail and receives a tag. The common data bus (CDB) marks entries complete. This block retires the oldest completed entry each cycle toward the register bank, handing back the ROB tag so the bank can clear its rename field only if that field still names this entry.

## Interface
- ROB_DEPTH, 8, entry count; power of two.
- TAG_W, 3, ROB tag width; log2(ROB_DEPTH).
- DATA_W, 16, result width.
- REG_W, 4, architectural register index width.
- clk1  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  issue requests an entry.
- alloc_func  in  4  opcode; 0000/0001 add/sub, 0010/0011 mul, 01xx branch.
- alloc_rd  in  REG_W  destination register.
- alloc_ready  out  1  entry available; allocation occurs on alloc_valid && alloc_ready.
- alloc_tag  out  TAG_W  tag of the entry being allocated (equals tail_p).
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  TAG_W  tag of the completing entry.
- cdb_data  in  DATA_W  result value.
- commit_valid  out  1  head entry is retiring.
- commit_ready  in  1  register bank accepts the retirement.
- commit_we  out  1  write the register; 0 for the branch class.
- commit_rd  out  REG_W  destination register.
- commit_data  out  DATA_W  result value.
- commit_tag  out  TAG_W  tag of the retiring entry (equals head_p).
- flush  in  1  synchronous clear of all entries.
- head_p, tail_p  out  TAG_W  ROB pointers.
- count  out  TAG_W+1  number of occupied entries.

## Operation
- Per-entry state: valid, ready, func, rd, data.
- Allocate: set valid=1 and ready=0 at tail_p, store func/rd, advance tail_p modulo ROB_DEPTH.
- CDB: if valid[cdb_tag] is set, set ready and store data. A CDB on an invalid tag is ignored.
- Commit: commit_valid = valid[head_p] && ready[head_p]. On commit_valid && commit_ready, clear valid[head_p] and advance head_p.
- commit_we = commit_valid && (func[3:2] != 2'b01).
- At most one allocation and one commit per cycle.
- count: +1 on allocate only, -1 on commit only, unchanged when both or neither occur.
- alloc_ready = (count != ROB_DEPTH).
  - Based on registered count; a full ROB rejects allocation even while committing that cycle.
- Empty ROB (count==0): commit_valid=0.
  - An entry allocated this cycle is not ready, so it cannot commit in the same cycle.
- CDB and allocation hitting the same index in one cycle: allocation wins (ready=0). This cannot happen for a live tag.
- Flush: clear all valid/ready bits and set head_p=tail_p=count=0. Flush overrides allocate, CDB and commit in the same cycle; commit_valid is still shown combinationally but the handshake is discarded.
- Reset mid-operation: all state is cleared immediately and asynchronously, with no partial retirement.

## Timing
- Reset values:
  - head_p=0, tail_p=0, count=0.
  - alloc_ready=1, alloc_tag=0.
  - commit_valid=0, commit_we=0, commit_rd=0, commit_data=0, commit_tag=0.
  - All valid/ready bits 0.
- Outputs are combinational from registered state (plus the bypass path below).
- Allocate at edge N, CDB for that tag at edge M>N → commit_valid during cycle M+1 if the entry is at head.
- commit_valid holds, with stable rd/data/tag, until commit_ready is sampled high.
- Back-to-back ready entries retire one per cycle while commit_ready=1.
- Pointers wrap ROB_DEPTH-1 → 0.

## Configuration
- ROB_COMMIT_BYPASS_EN defined:
  - When the head is valid and not ready, and cdb_valid && cdb_tag==head_p, commit_valid asserts in the same cycle.
  - commit_data is taken from cdb_data.
  - On handshake the entry retires at that edge, so completion-to-commit latency is 0 cycles.
- Undefined: the 1-cycle latency above applies; no combinational path from cdb_* to commit_*.

## Test plan
- Reset then idle:
  - all outputs at reset values; alloc_ready=1; count=0.
- Allocate add to r3 (tag 0), CDB tag 0 data 16'h0042 at the next edge, commit_ready=1:
  - commit_valid one cycle later with rd=3, data=0x0042, we=1, tag=0; count returns to 0.
- Out-of-order completion: allocate tags 0,1,2, then CDB tag 2, then 1, then 0:
  - nothing retires until tag 0 completes.
  - tags 0,1,2 then retire on three consecutive cycles in order.
- Fill 8 entries:
  - alloc_ready=0 and count=8.
  - simultaneous alloc+commit: allocation rejected, count=7 after the edge.
  - tail_p wraps to 0 after 8 allocations.
- Branch entry (func 0100) completes with commit_ready held low 3 cycles:
  - commit_valid stays high with we=0 and stable tag.
  - retires on the cycle commit_ready rises.
- Flush with 5 entries pending (and separately, rst_n pulsed mid-stream):
  - head_p=tail_p=count=0 and commit_valid=0 next cycle.
  - a CDB on an old tag is ignored.
  - with ROB_COMMIT_BYPASS_EN, CDB to head retires in the same cycle.
